dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (u_dmem) between two requesters: the pipeline MEM stage (port C) and a debug/program-loader port (port D).
- Issues one memory transaction at a time and returns read data with a valid strobe.
- Raises a stall to the pipeline while a core access is pending or in flight.
- Sits between riscv_pipeline's MEM stage and u_dmem.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width.
- MEM_LAT, 1, RAM read latency in cycles (1..4).
- STARVE_MAX, 4, consecutive core grants allowed while D waits before D is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- c_req  in  1  core request.
- c_we  in  1  core write enable.
- c_addr  in  AW  core byte address.
- c_wdata  in  DW  core write data.
- c_be  in  4  core byte enables.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DW  core read data.
- c_stall  out  1  stall for the pipeline.
- d_req  in  1  debug request.
- d_we  in  1  debug write enable.
- d_addr  in  AW  debug byte address.
- d_wdata  in  DW  debug write data.
- d_be  in  4  debug byte enables.
- d_lock  in  1  debug holds ownership across back-to-back requests.
- d_gnt  out  1  debug request accepted.
- d_rvalid  out  1  debug read data valid.
- d_rdata  out  DW  debug read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write.
- mem_addr  out  AW-2  RAM word index, equal to addr[AW-1:2].
- mem_wdata  out  DW  RAM write data.
- mem_be  out  4  RAM byte enables.
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; FSM in IDLE.
  - Starvation counter, lat counter and owner all 0.
  - An in-flight read is dropped: no rvalid is ever produced for it.
- FSM states:
  - IDLE: no transaction in flight. If any request is present, arbitrate. The winner gets gnt=1 for exactly one cycle, and that same cycle drives mem_en=1 with its we/addr/wdata/be.
    - Write → WR.
    - Read → RD, with lat counter loaded to MEM_LAT.
  - WR: one cycle, no memory activity. Next state is IDLE. A write therefore occupies two cycles; a new grant is possible on the cycle after WR.
  - RD: the counter decrements each cycle. When it reaches 0, the owner's rvalid=1 for one cycle with rdata=mem_rdata, and the FSM goes to IDLE in the same cycle.
- No grant while in WR or RD; there is one outstanding transaction maximum.
- rdata of the non-owning port holds its last value; rvalid is strictly one-cycle.
- Arbitration in IDLE:
  1. If d_lock=1 and the last owner was D and d_req=1: grant D.
  2. Else if d_req=1 and starve_cnt>=STARVE_MAX: grant D.
  3. Else if c_req=1: grant C.
  4. Else if d_req=1: grant D.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each C grant made while d_req=1.
  - Clears on any D grant, or when d_req=0 in IDLE.
- c_stall = c_req & ~c_gnt, OR (an owner=C read is in flight and rvalid not yet asserted).
  - A core write stalls only on its request cycle if it is not granted.
- Requesters must hold req and payload stable until gnt. Payload changes before gnt are undefined usage; the arbiter samples only on the gnt cycle.
- addr[1:0] is ignored; byte lanes are selected only by be. be=0 with we=1 still performs a no-op write cycle and returns through the FSM normally.
- Simultaneous c_req and d_req with starve_cnt<STARVE_MAX and no lock: C wins and D keeps waiting.
- d_lock deasserting mid-transaction has no effect until the next IDLE arbitration.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_c_grants[31:0], perf_d_grants[31:0] and perf_stall_cycles[31:0].
  - Counters are free-running, wrapping, reset to 0, and increment on c_gnt, d_gnt and c_stall respectively.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, WR, RD}.
  - owner enum {OWN_C, OWN_D}.
  - localparam BE_W=4.
- One sub-module, dmem_arb_prio: purely combinational priority/starvation select, taking d_lock, last owner, starve_cnt, c_req and d_req and returning grant_c/grant_d.
- FSM, counters and muxing stay in dmem_arbiter.

Test Plan:
- Core write c_addr=0x8, c_wdata=12, c_be=0xF, d_req=0 → c_gnt on cycle 1 with mem_en=1, mem_we=1, mem_addr=2; c_stall=0; the next grant is possible on cycle 3.
- Core read of addr 0x8 with MEM_LAT=1 → c_gnt cycle N, c_rvalid=1 and c_rdata=12 at cycle N+2; c_stall=1 for cycles N..N+1 and 0 at N+2.
- c_req and d_req both held continuously with reads, STARVE_MAX=4 → grant sequence C,C,C,C,D,C,C,C,C,D; d_rdata is delivered only on D transactions.
- d_lock=1 with 3 back-to-back debug writes while c_req=1 → D, D, D granted consecutively, then C; c_stall stays high throughout the D burst.
- Assert rst=0 during RD with one cycle left → no c_rvalid; all outputs 0 immediately; after release, a core read completes normally.
- With DMEM_ARB_PERF_EN defined, run the starvation scenario for 10 grants → perf_c_grants=8, perf_d_grants=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, transaction owner
// and the byte-enable width.
package dmem_arb_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_prio.sv
// Combinational winner select between the core port (C) and the debug port (D):
// debug lock, then starvation relief, then core, then debug.
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             d_lock,
    input  logic             last_owner,
    input  logic [CNT_W-1:0] starve_cnt,
    input  logic             c_req,
    input  logic             d_req,
    output logic             grant_c,
    output logic             grant_d
);

    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (d_lock && (last_owner == OWN_D) && d_req) begin
            grant_d = 1'b1;
        end else if (d_req && (starve_cnt >= CNT_W'(STARVE_MAX))) begin
            grant_d = 1'b1;
        end else if (c_req) begin
            grant_c = 1'b1;
        end else if (d_req) begin
            grant_d = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the pipeline MEM stage (C) and a debug port (D).
// Defining DMEM_ARB_PERF_EN adds grant and stall performance counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    input  logic [BE_W-1:0] c_be,
    output logic            c_gnt,
    output logic            c_rvalid,
    output logic [DW-1:0]   c_rdata,
    output logic            c_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [BE_W-1:0] d_be,
    input  logic            d_lock,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-3:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]     perf_c_grants,
    output logic [31:0]     perf_d_grants,
    output logic [31:0]     perf_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             c_rvalid_q, c_rvalid_d;
    logic             d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]    c_rdata_q, c_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;

    logic grant_c, grant_d;
    logic issue_c, issue_d;
    logic sel_we;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{c_addr[1:0], d_addr[1:0]};

    dmem_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .d_lock     (d_lock),
        .last_owner (owner_q == OWN_D),
        .starve_cnt (starve_q),
        .c_req      (c_req),
        .d_req      (d_req),
        .grant_c    (grant_c),
        .grant_d    (grant_d)
    );

    // Grants only exist in IDLE and are forced low while reset is held.
    assign issue_c = rst && (state_q == IDLE) && grant_c;
    assign issue_d = rst && (state_q == IDLE) && grant_d;
    assign sel_we  = issue_d ? d_we : c_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_C;
            starve_q   <= '0;
            lat_q      <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (issue_c || issue_d) begin
                    owner_d = issue_d ? OWN_D : OWN_C;
                    if (sel_we) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                        lat_d   = LAT_W'(MEM_LAT);
                    end
                end
                if (!d_req || issue_d) begin
                    starve_d = '0;
                end else if (issue_c && (starve_q < CNT_W'(STARVE_MAX))) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                // RAM data is valid on the last counted cycle; rvalid appears as we re-enter IDLE.
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end else begin
                        c_rvalid_d = 1'b1;
                        c_rdata_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        c_gnt     = issue_c;
        d_gnt     = issue_d;
        mem_en    = issue_c || issue_d;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (issue_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr[AW-1:2];
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (issue_c) begin
            mem_we    = c_we;
            mem_addr  = c_addr[AW-1:2];
            mem_wdata = c_wdata;
            mem_be    = c_be;
        end
        c_stall = rst && ((c_req && !issue_c) || (issue_c && !c_we) ||
                          ((state_q == RD) && (owner_q == OWN_C)));
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_c_q, perf_c_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_s_q, perf_s_d;

    always_comb begin
        perf_c_d = perf_c_q + 32'(issue_c);
        perf_d_d = perf_d_q + 32'(issue_d);
        perf_s_d = perf_s_q + 32'(c_stall);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_c_q <= '0;
            perf_d_q <= '0;
            perf_s_q <= '0;
        end else begin
            perf_c_q <= perf_c_d;
            perf_d_q <= perf_d_d;
            perf_s_q <= perf_s_d;
        end
    end

    assign perf_c_grants     = perf_c_q;
    assign perf_d_grants     = perf_d_q;
    assign perf_stall_cycles = perf_s_q;
`endif

endmodule
